// File: rtl/msu_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msu_audio_pkg
//  Description : Shared types and constants for the MSU audio sample player:
//                FSM state encoding, MSU1 header signature words, header
//                length, fetcher flow-control threshold and the volume scaler.
//  Revision    : 1.0  initial release
// ============================================================================
package msu_audio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_POP_L = 2'd1,
      ST_POP_R = 2'd2,
      ST_SCALE = 2'd3
   } msu_audio_state_t;

   localparam logic [15:0] MSU_SIG_LO = 16'h534D;   // "MS"
   localparam logic [15:0] MSU_SIG_HI = 16'h3155;   // "U1"
   localparam int          HDR_WORDS  = 4;

   // Fetcher stops requesting sectors once the FIFO holds this many words
   localparam int          USEDW_THRESHOLD = 1792;

   // Signed sample times unsigned 8-bit gain (255 ~ unity), result >>> 8
   function automatic logic [15:0] msu_scale(input logic [15:0] sample,
                                             input logic [7:0]  vol);
      logic signed [24:0] s_ext;
      logic signed [24:0] v_ext;
      s_ext = {{9{sample[15]}}, sample};
      v_ext = {17'd0, vol};
      return 16'((s_ext * v_ext) >>> 8);
   endfunction

endpackage
`default_nettype wire

// File: rtl/msu_audio_sample_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : msu_audio_sample_player_if
//  Description : Bundle between the MSU audio fetcher / mixer side (master)
//                and the sample player (slave): SD word stream, control,
//                flow-control feedback and stereo audio output.
//  Revision    : 1.0  initial release
// ============================================================================
interface msu_audio_sample_player_if #(
   parameter int USEDW_W = 12
);
   logic               track_start;
   logic               playing;
   logic               sd_ack;
   logic               sd_buff_wr;
   logic [15:0]        sd_buff_dout;
   logic               ignore_sd_buffer;
   logic [7:0]         volume;
   logic [USEDW_W-1:0] audio_fifo_usedw;
   logic [31:0]        loop_index;
   logic               header_valid;
   logic               header_error;
   logic [15:0]        audio_l;
   logic [15:0]        audio_r;
   logic               audio_valid;
   logic               underflow;
   logic               overflow;

   modport master (
      output track_start, playing, sd_ack, sd_buff_wr, sd_buff_dout,
             ignore_sd_buffer, volume,
      input  audio_fifo_usedw, loop_index, header_valid, header_error,
             audio_l, audio_r, audio_valid, underflow, overflow
   );

   modport slave (
      input  track_start, playing, sd_ack, sd_buff_wr, sd_buff_dout,
             ignore_sd_buffer, volume,
      output audio_fifo_usedw, loop_index, header_valid, header_error,
             audio_l, audio_r, audio_valid, underflow, overflow
   );
endinterface
`default_nettype wire

// File: rtl/msu_audio_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : msu_audio_fifo
//  Description : Single-clock first-word-fall-through FIFO of 16-bit words.
//                dout_o shows the head whenever the FIFO is not empty.
//                A push while full is dropped unless a pop frees a slot in
//                the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module msu_audio_fifo #(
   parameter int DEPTH   = 2048,
   parameter int USEDW_W = 12
) (
   input  wire logic               clk,
   input  wire logic               flush_i,
   input  wire logic               push_i,
   input  wire logic               pop_i,
   input  wire logic [15:0]        din_i,
   output logic      [15:0]        dout_o,
   output logic      [USEDW_W-1:0] usedw_o,
   output logic                    full_o,
   output logic                    empty_o
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [15:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0]  wr_ptr_q;
   logic [ADDR_W-1:0]  rd_ptr_q;
   logic [USEDW_W-1:0] count_q;
   logic               w_do_push;
   logic               w_do_pop;

   assign full_o    = (count_q == USEDW_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign w_do_pop  = pop_i & ~empty_o;
   assign w_do_push = push_i & (~full_o | w_do_pop);
   assign dout_o    = mem_q[rd_ptr_q];
   assign usedw_o   = count_q;

   // Storage array, no reset needed since pointers define validity
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // Pointer and occupancy tracking; flush empties the FIFO
   always_ff @(posedge clk) begin
      if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         if (w_do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   count_q <= count_q + USEDW_W'(1);
            2'b01:   count_q <= count_q - USEDW_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/msu_audio_sample_player.sv
`default_nettype none
// ============================================================================
//  Module      : msu_audio_sample_player
//  Description : Parses the 8-byte MSU1 track header from the SD word stream,
//                buffers PCM words in a FWFT FIFO and plays stereo pairs at
//                SAMPLE_HZ with linear volume scaling.
//                Optional: MSU_AUDIO_SIGCHECK_EN enables signature checking
//                (header_error); otherwise header_error is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module msu_audio_sample_player
   import msu_audio_pkg::*;
#(
   parameter int CLK_HZ     = 21477270,
   parameter int SAMPLE_HZ  = 44100,
   parameter int FIFO_DEPTH = 2048,
   parameter int USEDW_W    = 12
) (
   input wire logic                 clk,
   input wire logic                 reset,
   msu_audio_sample_player_if.slave aud
);
   localparam logic [31:0] C_CLK_HZ    = 32'(CLK_HZ);
   localparam logic [31:0] C_SAMPLE_HZ = 32'(SAMPLE_HZ);

   // ---------------------------------------------------------------- input
   logic w_flush;
   logic w_accept;
   logic w_in_hdr;
   logic w_push;
   logic w_pop;
   logic w_hdr_err;

   // track_start and reset both return every piece of state to its idle value
   assign w_flush  = reset | aud.track_start;
   assign w_accept = aud.sd_ack & aud.sd_buff_wr & ~aud.ignore_sd_buffer;

   // --------------------------------------------------------------- header
   logic [2:0]  hdr_cnt_q;
   logic [31:0] loop_index_q;
   logic        header_valid_q;

   assign w_in_hdr = (hdr_cnt_q < 3'(HDR_WORDS));

   // Count header words, capture the loop index, flag completion
   always_ff @(posedge clk) begin
      if (w_flush) begin
         hdr_cnt_q      <= '0;
         loop_index_q   <= '0;
         header_valid_q <= 1'b0;
      end else if (w_accept && w_in_hdr) begin
         hdr_cnt_q <= hdr_cnt_q + 3'd1;
         if (hdr_cnt_q == 3'd2) begin
            loop_index_q[15:0] <= aud.sd_buff_dout;
         end
         if (hdr_cnt_q == 3'd3) begin
            loop_index_q[31:16] <= aud.sd_buff_dout;
            header_valid_q      <= ~w_hdr_err;
         end
      end
   end

`ifdef MSU_AUDIO_SIGCHECK_EN
   logic header_error_q;
   logic w_sig_bad;

   // Compare the two signature words against "MSU1"
   always_comb begin
      w_sig_bad = 1'b0;
      if (w_accept && (hdr_cnt_q == 3'd0) && (aud.sd_buff_dout != MSU_SIG_LO)) begin
         w_sig_bad = 1'b1;
      end
      if (w_accept && (hdr_cnt_q == 3'd1) && (aud.sd_buff_dout != MSU_SIG_HI)) begin
         w_sig_bad = 1'b1;
      end
   end

   // Sticky signature error, cleared only by a flush
   always_ff @(posedge clk) begin
      if (w_flush) begin
         header_error_q <= 1'b0;
      end else if (w_sig_bad) begin
         header_error_q <= 1'b1;
      end
   end

   assign w_hdr_err = header_error_q;
`else
   assign w_hdr_err = 1'b0;
`endif

   // A bad header blocks playback, so its data words are discarded too
   assign w_push = w_accept & ~w_in_hdr & ~w_hdr_err;

   // ----------------------------------------------------------------- FIFO
   logic [15:0]        w_fifo_dout;
   logic [USEDW_W-1:0] w_fifo_usedw;
   logic               w_fifo_full;
   logic               w_fifo_empty;

   msu_audio_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .USEDW_W (USEDW_W)
   ) u_fifo (
      .clk     (clk),
      .flush_i (w_flush),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .din_i   (aud.sd_buff_dout),
      .dout_o  (w_fifo_dout),
      .usedw_o (w_fifo_usedw),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty)
   );

   logic overflow_q;

   // Sticky overflow: the word was dropped because no slot was free
   always_ff @(posedge clk) begin
      if (w_flush) begin
         overflow_q <= 1'b0;
      end else if (w_push && w_fifo_full && !w_pop) begin
         overflow_q <= 1'b1;
      end
   end

   // ------------------------------------------------------- tick generator
   logic [31:0] phase_q;
   logic [31:0] phase_d;
   logic [31:0] w_phase_sum;
   logic        w_tick;

   // Fractional accumulator: one tick each time phase crosses CLK_HZ
   always_comb begin
      w_phase_sum = phase_q + C_SAMPLE_HZ;
      w_tick      = (w_phase_sum >= C_CLK_HZ);
      phase_d     = w_tick ? (w_phase_sum - C_CLK_HZ) : w_phase_sum;
   end

   // ------------------------------------------------------------- playback
   msu_audio_state_t state_q, state_d;
   logic [15:0] l_q, l_d;
   logic [15:0] audio_l_q, audio_l_d;
   logic [15:0] audio_r_q, audio_r_d;
   logic        audio_valid_q, audio_valid_d;
   logic        underflow_q, underflow_d;

   // Next-state and datapath decode. The scaled pair is registered on leaving
   // POP_R (R taken straight off the FIFO head), so SCALE is the cycle in
   // which the result and audio_valid are presented, 3 cycles after the tick.
   always_comb begin
      state_d       = state_q;
      w_pop         = 1'b0;
      l_d           = l_q;
      audio_l_d     = audio_l_q;
      audio_r_d     = audio_r_q;
      audio_valid_d = 1'b0;
      underflow_d   = underflow_q;
      case (state_q)
         ST_IDLE: begin
            if (w_tick) begin
               if (!aud.playing) begin
                  audio_l_d = '0;
                  audio_r_d = '0;
               end else if (header_valid_q) begin
                  if (w_fifo_usedw >= USEDW_W'(2)) begin
                     state_d = ST_POP_L;
                  end else begin
                     underflow_d = 1'b1;
                  end
               end
            end
         end
         ST_POP_L: begin
            l_d     = w_fifo_empty ? 16'd0 : w_fifo_dout;
            w_pop   = 1'b1;
            state_d = ST_POP_R;
         end
         ST_POP_R: begin
            audio_l_d     = msu_scale(l_q, aud.volume);
            audio_r_d     = msu_scale(w_fifo_empty ? 16'd0 : w_fifo_dout, aud.volume);
            audio_valid_d = 1'b1;
            w_pop         = 1'b1;
            state_d       = ST_SCALE;
         end
         ST_SCALE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, phase and output registers
   always_ff @(posedge clk) begin
      if (w_flush) begin
         state_q       <= ST_IDLE;
         phase_q       <= '0;
         l_q           <= '0;
         audio_l_q     <= '0;
         audio_r_q     <= '0;
         audio_valid_q <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         l_q           <= l_d;
         audio_l_q     <= audio_l_d;
         audio_r_q     <= audio_r_d;
         audio_valid_q <= audio_valid_d;
         underflow_q   <= underflow_d;
      end
   end

   // -------------------------------------------------------------- outputs
   assign aud.audio_fifo_usedw = w_fifo_usedw;
   assign aud.loop_index       = loop_index_q;
   assign aud.header_valid     = header_valid_q;
   assign aud.header_error     = w_hdr_err;
   assign aud.audio_l          = audio_l_q;
   assign aud.audio_r          = audio_r_q;
   assign aud.audio_valid      = audio_valid_q;
   assign aud.underflow        = underflow_q;
   assign aud.overflow         = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_msu_audio_sample_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msu_audio_sample_player
//  Description : Self-checking bench for msu_audio_sample_player. Expected
//                stereo pairs go into a scoreboard when data is written and
//                are compared when audio_valid pulses. The sample clock is
//                scaled so a tick occurs every 10 cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_msu_audio_sample_player;
   localparam int T_CLK_HZ    = 441000;
   localparam int T_SAMPLE_HZ = 44100;
   localparam int T_DEPTH     = 2048;
   localparam int T_USEDW_W   = 12;

   logic clk;
   logic reset;

   msu_audio_sample_player_if #(.USEDW_W(T_USEDW_W)) aud();

   msu_audio_sample_player #(
      .CLK_HZ     (T_CLK_HZ),
      .SAMPLE_HZ  (T_SAMPLE_HZ),
      .FIFO_DEPTH (T_DEPTH),
      .USEDW_W    (T_USEDW_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .aud   (aud)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks;
   int          n_fails;
   int          n_valid_seen;
   int          n_valid_exp;
   logic [15:0] exp_l_q[$];
   logic [15:0] exp_r_q[$];

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Independent reference for the volume stage
   function automatic logic [15:0] model_scale(input logic [15:0] s, input logic [7:0] v);
      int p;
      p = int'($signed(s)) * int'({24'd0, v});
      p = p >>> 8;
      return p[15:0];
   endfunction

   task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
      exp_l_q.push_back(l);
      exp_r_q.push_back(r);
      n_valid_exp++;
   endtask

   // Scoreboard consumer
   always @(negedge clk) begin
      if (!reset && aud.audio_valid === 1'b1) begin : mon
         logic [15:0] el;
         logic [15:0] er;
         n_valid_seen++;
         if (exp_l_q.size() == 0) begin
            chk_eq("unexpected_valid", 32'd1, 32'd0);
         end else begin
            el = exp_l_q.pop_front();
            er = exp_r_q.pop_front();
            chk_eq("audio_l", {16'd0, aud.audio_l}, {16'd0, el});
            chk_eq("audio_r", {16'd0, aud.audio_r}, {16'd0, er});
         end
      end
   end

   task automatic put_word(input logic [15:0] w, input logic ign, input logic ack);
      aud.sd_ack           = ack;
      aud.sd_buff_wr       = 1'b1;
      aud.sd_buff_dout     = w;
      aud.ignore_sd_buffer = ign;
      @(posedge clk); #1;
      aud.sd_buff_wr       = 1'b0;
      aud.ignore_sd_buffer = 1'b0;
   endtask

   task automatic send_header(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] lo, input logic [15:0] hi);
      put_word(w0, 1'b0, 1'b1);
      put_word(w1, 1'b0, 1'b1);
      put_word(lo, 1'b0, 1'b1);
      put_word(hi, 1'b0, 1'b1);
   endtask

   task automatic pulse_track_start();
      aud.track_start = 1'b1;
      @(posedge clk); #1;
      aud.track_start = 1'b0;
   endtask

   // Play until every queued pair has appeared, bounded by a cycle budget
   task automatic play_and_drain(input int budget);
      aud.playing = 1'b1;
      for (int c = 0; c < budget && n_valid_seen < n_valid_exp; c++) @(posedge clk);
      #1;
      aud.playing = 1'b0;
      chk_eq("valid_count", n_valid_seen, n_valid_exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] wl;
      logic [15:0] wr;
      logic [15:0] wprev;
      n_checks     = 0;
      n_fails      = 0;
      n_valid_seen = 0;
      n_valid_exp  = 0;
      wprev        = '0;
      reset                = 1'b1;
      aud.track_start      = 1'b0;
      aud.playing          = 1'b0;
      aud.sd_ack           = 1'b0;
      aud.sd_buff_wr       = 1'b0;
      aud.sd_buff_dout     = '0;
      aud.ignore_sd_buffer = 1'b0;
      aud.volume           = 8'd255;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      chk_eq("rst_usedw",     aud.audio_fifo_usedw, 0);
      chk_eq("rst_hdr_valid", aud.header_valid, 0);
      chk_eq("rst_hdr_error", aud.header_error, 0);
      chk_eq("rst_loop",      aud.loop_index, 0);
      chk_eq("rst_audio_l",   aud.audio_l, 0);
      chk_eq("rst_audio_r",   aud.audio_r, 0);
      chk_eq("rst_valid",     aud.audio_valid, 0);
      chk_eq("rst_underflow", aud.underflow, 0);
      chk_eq("rst_overflow",  aud.overflow, 0);

      // Header parse
      send_header(16'h534D, 16'h3155, 16'h0014, 16'h0000);
      chk_eq("hdr_valid", aud.header_valid, 1);
      chk_eq("hdr_loop",  aud.loop_index, 32'd20);
      chk_eq("hdr_error", aud.header_error, 0);
      chk_eq("hdr_usedw", aud.audio_fifo_usedw, 0);

      // First pair at unity volume
      put_word(16'h1000, 1'b0, 1'b1);
      put_word(16'hF000, 1'b0, 1'b1);
      chk_eq("pair_usedw2", aud.audio_fifo_usedw, 2);
      push_pair(16'h0FF0, 16'hF010);
      play_and_drain(100);
      chk_eq("pair_usedw0", aud.audio_fifo_usedw, 0);

      // Ignored / unacknowledged strobes, then L/R parity intact
      put_word(16'h2222, 1'b1, 1'b1);
      put_word(16'h3333, 1'b0, 1'b0);
      chk_eq("ignore_usedw", aud.audio_fifo_usedw, 0);
      aud.sd_ack = 1'b1;
      aud.volume = 8'd128;
      put_word(16'h0100, 1'b0, 1'b1);
      put_word(16'h0200, 1'b0, 1'b1);
      push_pair(16'h0080, 16'h0100);
      play_and_drain(100);

      // Random pairs at random volume
      aud.volume = 8'($urandom_range(1, 255));
      for (int i = 0; i < 4; i++) begin
         wl = 16'($urandom);
         wr = 16'($urandom);
         put_word(wl, 1'b0, 1'b1);
         put_word(wr, 1'b0, 1'b1);
         push_pair(model_scale(wl, aud.volume), model_scale(wr, aud.volume));
      end
      chk_eq("rand_usedw8", aud.audio_fifo_usedw, 8);
      play_and_drain(200);
      chk_eq("rand_usedw0", aud.audio_fifo_usedw, 0);

      // Stopped: next tick returns outputs to zero, no underflow
      repeat (15) @(posedge clk); #1;
      chk_eq("stop_audio_l",  aud.audio_l, 0);
      chk_eq("stop_audio_r",  aud.audio_r, 0);
      chk_eq("stop_underflow", aud.underflow, 0);

      // Underflow with a single word buffered
      put_word(16'h4444, 1'b0, 1'b1);
      aud.playing = 1'b1;
      for (int c = 0; c < 40 && aud.underflow !== 1'b1; c++) @(posedge clk);
      #1;
      aud.playing = 1'b0;
      chk_eq("uf_flag",  aud.underflow, 1);
      chk_eq("uf_usedw", aud.audio_fifo_usedw, 1);
      chk_eq("uf_no_valid", n_valid_seen, n_valid_exp);

      // track_start with a coincident strobe: flush, and the word is dropped
      aud.track_start = 1'b1;
      put_word(16'h534D, 1'b0, 1'b1);
      aud.track_start = 1'b0;
      chk_eq("ts_underflow", aud.underflow, 0);
      chk_eq("ts_usedw",     aud.audio_fifo_usedw, 0);
      chk_eq("ts_hdr_valid", aud.header_valid, 0);
      chk_eq("ts_loop",      aud.loop_index, 0);
      send_header(16'h534D, 16'h3155, 16'hBEEF, 16'h1234);
      chk_eq("ts_hdr_valid2", aud.header_valid, 1);
      chk_eq("ts_loop2",      aud.loop_index, 32'h1234BEEF);

      // Fill to full, one extra word overflows and is lost
      aud.volume = 8'd255;
      for (int i = 0; i < T_DEPTH; i++) begin
         wl = 16'(i * 37 + 5);
         put_word(wl, 1'b0, 1'b1);
         if (i % 2 == 1) push_pair(model_scale(wprev, 8'd255), model_scale(wl, 8'd255));
         wprev = wl;
      end
      chk_eq("full_overflow_pre", aud.overflow, 0);
      put_word(16'hDEAD, 1'b0, 1'b1);
      chk_eq("full_usedw",    aud.audio_fifo_usedw, T_DEPTH);
      chk_eq("full_overflow", aud.overflow, 1);
      play_and_drain(T_DEPTH / 2 * 10 + 200);
      chk_eq("drain_usedw", aud.audio_fifo_usedw, 0);

      // Signature handling
      pulse_track_start();
      send_header(16'h0000, 16'h3155, 16'h0014, 16'h0000);
`ifdef MSU_AUDIO_SIGCHECK_EN
      chk_eq("sig_error", aud.header_error, 1);
      chk_eq("sig_valid", aud.header_valid, 0);
      put_word(16'h1111, 1'b0, 1'b1);
      put_word(16'h2222, 1'b0, 1'b1);
      chk_eq("sig_usedw", aud.audio_fifo_usedw, 0);
      pulse_track_start();
      chk_eq("sig_clr_error", aud.header_error, 0);
      chk_eq("sig_clr_valid", aud.header_valid, 0);
      chk_eq("sig_clr_ovf",   aud.overflow, 0);
      chk_eq("sig_clr_usedw", aud.audio_fifo_usedw, 0);
`else
      chk_eq("nosig_error", aud.header_error, 0);
      chk_eq("nosig_valid", aud.header_valid, 1);
      chk_eq("nosig_loop",  aud.loop_index, 32'd20);
      pulse_track_start();
      chk_eq("nosig_clr_ovf",   aud.overflow, 0);
      chk_eq("nosig_clr_usedw", aud.audio_fifo_usedw, 0);
`endif

      repeat (5) @(posedge clk); #1;
      chk_eq("sb_leftover", exp_l_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/msu_audio_sample_player.md
Name: msu_audio_sample_player

Overview:
Consumes the 16-bit words streamed from the SD sector buffer by the MSU audio sector fetcher, parses the 8-byte MSU track header, and buffers the PCM words in an on-chip FIFO. It pops stereo L/R pairs at 44.1 kHz, applies the volume, and drives the audio mixer. It returns the FIFO fill level (audio_fifo_usedw) and the parsed loop index to the fetcher, closing the flow-control loop.

Parameters:
CLK_HZ, 21477270, system clock frequency, used by the sample-rate divider
SAMPLE_HZ, 44100, output stereo frame rate
FIFO_DEPTH, 2048, FIFO depth in 16-bit words; must be a power of 2
USEDW_W, 12, width of audio_fifo_usedw; equals log2(FIFO_DEPTH)+1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
track_start  in  1  one-cycle pulse: new track triggered; flushes all state
playing  in  1  fetcher play flag; when low, no pops and outputs return to 0
sd_ack  in  1  SD transfer active (fetcher channel)
sd_buff_wr  in  1  word strobe from the SD buffer
sd_buff_dout  in  16  little-endian data word
ignore_sd_buffer  in  1  high = discard this word (loop-point skip)
volume  in  8  linear gain; 255 = unity
audio_fifo_usedw  out  USEDW_W  FIFO words in use
loop_index  out  32  loop sample index from the header
header_valid  out  1  header fully parsed
header_error  out  1  signature mismatch (sticky until track_start)
audio_l  out  16  signed left sample
audio_r  out  16  signed right sample
audio_valid  out  1  one-cycle pulse when audio_l/audio_r update
underflow  out  1  sticky: tick with fewer than 2 words available
overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset values: all outputs 0; FIFO empty; header counter 0; state IDLE; phase accumulator 0.
- track_start has the same effect as reset, except volume-independent state is all that exists, so the two are equivalent. If asserted together with a word strobe, the word is dropped.
- Accepted word: sd_ack && sd_buff_wr && !ignore_sd_buffer.
- Header parsing: the first 4 accepted words after reset or track_start are header words.
  - words 0 and 1 are the signature, 0x534D then 0x3155 ("MSU1").
  - word 2 is loaded into loop_index[15:0]; word 3 into loop_index[31:16].
  - header_valid rises the cycle after word 3 is accepted.
  - Header words are never written to the FIFO.
- Data: accepted words after the header are written to the FIFO in order. Even-numbered words are L and odd-numbered words are R. Parity is reset by a flush.
- FIFO full on write: the word is dropped and overflow is set. A simultaneous push and pop is legal, and usedw is unchanged.
- Tick generator: phase += SAMPLE_HZ every cycle. When phase >= CLK_HZ, phase -= CLK_HZ and tick is pulsed for one cycle. Phase register width is 32 bits.
- FSM IDLE -> POP_L -> POP_R -> SCALE -> IDLE:
  - IDLE: on tick && playing && header_valid:
    - usedw >= 2: go to POP_L.
    - else: set underflow, hold the last outputs, stay in IDLE.
  - POP_L: latch the FIFO head into the L register and pop.
  - POP_R: latch into the R register and pop.
  - SCALE: compute out = (sample * {1'b0,volume}) >>> 8 as a signed 25-bit product; take bits [23:8].
    - Register into audio_l/audio_r and pulse audio_valid.
- Latency: audio_valid is asserted 3 cycles after the tick.
- A tick arriving while not in IDLE is ignored. This cannot occur at legal parameters.
- playing low: the FSM finishes any pair in progress, then audio_l/audio_r are set to 0 on the next tick. No pops occur.
- FIFO read is first-word-fall-through: the head is valid whenever usedw > 0.

Optional Feature:
MSU_AUDIO_SIGCHECK_EN
- Defined: if a signature word mismatches, header_error is set. header_valid is never raised, so no playback occurs. Data words are still discarded.
- Undefined: signature words are skipped unchecked, and header_error is tied to 0.

Decomposition:
- Package msu_audio_pkg holds:
  - the FSM state enum;
  - MSU_SIG_LO = 16'h534D, MSU_SIG_HI = 16'h3155;
  - HDR_WORDS = 4;
  - the usedw flow-control threshold 1792 shared with the fetcher.
- Sub-module msu_audio_fifo: single-clock first-word-fall-through FIFO with inputs push/pop/flush and outputs dout/usedw/full/empty.

Test Plan:
- Header "MSU1", then loop words 0x0014 and 0x0000 -> header_valid=1, loop_index=20, header_error=0, usedw=0.
- Header, then data words 0x1000, 0xF000, volume=255 -> audio_valid with audio_l=0x0FF0 and audio_r=0xF010 (-4080); usedw goes 2 -> 0.
- Data words strobed with ignore_sd_buffer=1 -> usedw unchanged; the next accepted word is still L.
- 2049 data words with playing=0 -> usedw=2048, overflow=1, then the 2049th word is absent.
- playing=1 with only 1 word buffered -> underflow=1 at the tick, no audio_valid, usedw stays 1.
- With MSU_AUDIO_SIGCHECK_EN defined, header word0=0x0000 -> header_error=1 and header_valid=0. A track_start pulse then clears all flags and empties the FIFO.
